// File: rtl/done_batch_monitor_pkg.sv
// Shared types for the done-pulse batch monitor: state encoding and a debug name decode.
package done_batch_monitor_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REPORT  = 2'd2,
    ST_ERROR   = 2'd3
  } state_e;

  // Human-readable state name for simulation debug and waveform annotation.
  function automatic string state_name(state_e s);
    case (s)
      ST_IDLE:    return "IDLE";
      ST_COLLECT: return "COLLECT";
      ST_REPORT:  return "REPORT";
      ST_ERROR:   return "ERROR";
      default:    return "UNKNOWN";
    endcase
  endfunction

endpackage

// File: rtl/done_batch_monitor_if.sv
// Control/status bundle between the monitor and its software-facing consumer.
interface done_batch_monitor_if #(
  parameter int unsigned CW = 3,
  parameter int unsigned GW = 5
) ();

  logic          enable;
  logic          done_in;
  logic          irq_ack;
  logic          irq;
  logic          err;
  logic          ovf;
  logic [CW-1:0] batch_cnt;
  logic [GW-1:0] gap_max;

  modport master (
    output enable, done_in, irq_ack,
    input  irq, err, ovf, batch_cnt, gap_max
  );

  modport slave (
    input  enable, done_in, irq_ack,
    output irq, err, ovf, batch_cnt, gap_max
  );

endinterface

// File: rtl/done_batch_monitor_gap_timer.sv
// Saturating counter of idle cycles since the last done pulse, with timeout flag.
module gap_timer #(
  parameter int unsigned TMO = 31,
  parameter int unsigned GW  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          freeze,
  output logic [GW-1:0] g,
  output logic          tmo_hit
);

  localparam logic [GW-1:0] G_LIMIT = GW'(TMO - 1);

  // Clear wins, freeze holds, otherwise count up and stop at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g <= '0;
    end else if (clr) begin
      g <= '0;
    end else if (inc && !freeze && (g != G_LIMIT)) begin
      g <= g + GW'(1);
    end
  end

  assign tmo_hit = inc && !freeze && (g == G_LIMIT);

endmodule

// File: rtl/done_batch_monitor.sv
// Batches done pulses into irq reports, flags stalls, and tracks the longest gap.
module done_batch_monitor
  import done_batch_monitor_pkg::*;
#(
  parameter int unsigned BATCH = 4,
  parameter int unsigned CW    = 3,
  parameter int unsigned TMO   = 31,
  parameter int unsigned GW    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  done_batch_monitor_if.slave  bus
);

  state_e        state;
  state_e        state_nxt;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;
  logic [GW-1:0] gmax_q;
  logic [GW-1:0] gmax_nxt;
  logic          ovf_q;
  logic          ovf_nxt;
  logic          irq_q;
  logic          err_q;
  logic [GW-1:0] g;
  logic          tmo_hit;
  logic          gap_clr;
  logic          gap_inc;
  logic          gap_freeze;

  // Gap timer controls: restart on every accepted pulse, ack, or while not running.
  assign gap_clr    = !bus.enable || (state == ST_IDLE)
                    || ((state == ST_COLLECT) && bus.done_in)
                    || ((state == ST_REPORT) && bus.irq_ack);
  assign gap_inc    = bus.enable && (state == ST_COLLECT) && !bus.done_in;
  assign gap_freeze = (state == ST_REPORT) || (state == ST_ERROR);

  gap_timer #(.TMO(TMO), .GW(GW)) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (gap_clr),
    .inc     (gap_inc),
    .freeze  (gap_freeze),
    .g       (g),
    .tmo_hit (tmo_hit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and next-value logic; enable low overrides everything.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    gmax_nxt  = gmax_q;
    ovf_nxt   = ovf_q;
    if (!bus.enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      gmax_nxt  = '0;
      ovf_nxt   = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          state_nxt = ST_COLLECT;
          cnt_nxt   = '0;
          gmax_nxt  = '0;
          ovf_nxt   = 1'b0;
        end
        ST_COLLECT: begin
          if (bus.done_in) begin
            gmax_nxt = (g > gmax_q) ? g : gmax_q;
            if (cnt_q == CW'(BATCH - 1)) begin
              state_nxt = ST_REPORT;
              cnt_nxt   = CW'(BATCH);
            end else begin
              cnt_nxt = cnt_q + CW'(1);
            end
          end else if (tmo_hit) begin
            state_nxt = ST_ERROR;
          end
        end
        ST_REPORT: begin
          if (bus.irq_ack) begin
            state_nxt = ST_COLLECT;
            cnt_nxt   = bus.done_in ? CW'(1) : '0;
          end else if (bus.done_in) begin
            ovf_nxt = 1'b1;
          end
        end
        ST_ERROR: begin
          state_nxt = ST_ERROR;
        end
      endcase
    end
  end

  // Registered outputs, derived from the next state and next values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      gmax_q <= '0;
      ovf_q  <= 1'b0;
      irq_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      gmax_q <= gmax_nxt;
      ovf_q  <= ovf_nxt;
      irq_q  <= (state_nxt == ST_REPORT);
      err_q  <= (state_nxt == ST_ERROR);
    end
  end

  assign bus.irq       = irq_q;
  assign bus.err       = err_q;
  assign bus.ovf       = ovf_q;
  assign bus.batch_cnt = cnt_q;
  assign bus.gap_max   = gmax_q;

endmodule

// File: tb/tb_done_batch_monitor.sv
// Bench for done_batch_monitor: directed scenarios plus random traffic against a rule model.
module tb_done_batch_monitor;

  localparam int unsigned BATCH = 4;
  localparam int unsigned CW    = 3;
  localparam int unsigned TMO   = 31;
  localparam int unsigned GW    = 5;

  logic clk;
  logic rst;

  done_batch_monitor_if #(.CW(CW), .GW(GW)) bus ();

  done_batch_monitor #(.BATCH(BATCH), .CW(CW), .TMO(TMO), .GW(GW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Reference model: running / report-pending / stalled flags plus plain counters.
  bit m_run;
  bit m_pend;
  bit m_stall;
  bit m_ovf;
  int m_count;
  int m_gap;
  int m_gmax;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_stall = 0; m_ovf = 0;
    m_count = 0; m_gap = 0; m_gmax = 0;
  endtask

  task automatic model_step(input bit en, input bit d, input bit a);
    if (rst || !en) begin
      model_reset();
    end else if (!m_run) begin
      model_reset();
      m_run = 1;
    end else if (m_stall) begin
      // stalled: everything held until enable drops
    end else if (m_pend) begin
      if (a) begin
        m_pend  = 0;
        m_gap   = 0;
        m_count = d ? 1 : 0;
      end else if (d) begin
        m_ovf = 1;
      end
    end else if (d) begin
      if (m_gap > m_gmax) m_gmax = m_gap;
      m_gap = 0;
      m_count++;
      if (m_count == BATCH) m_pend = 1;
    end else if (m_gap == TMO - 1) begin
      m_stall = 1;
    end else begin
      m_gap++;
    end
  endtask

  task automatic compare_all(input string ctx);
    check_eq({ctx, ".irq"},       32'(bus.irq),       32'(m_pend));
    check_eq({ctx, ".err"},       32'(bus.err),       32'(m_stall));
    check_eq({ctx, ".ovf"},       32'(bus.ovf),       32'(m_ovf));
    check_eq({ctx, ".batch_cnt"}, 32'(bus.batch_cnt), 32'(m_count));
    check_eq({ctx, ".gap_max"},   32'(bus.gap_max),   32'(m_gmax));
  endtask

  // One clock: drive inputs, advance model at the edge, compare just after it.
  task automatic step(input bit en, input bit d, input bit a);
    bus.enable  = en;
    bus.done_in = d;
    bus.irq_ack = a;
    @(posedge clk);
    model_step(en, d, a);
    #1;
    compare_all("cyc");
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst = 1'b1;
    bus.enable  = 1'b1;
    bus.done_in = 1'b0;
    bus.irq_ack = 1'b0;

    // Reset held with enable high.
    step(1, 0, 0);
    step(1, 0, 0);
    check_eq("rst.irq", 32'(bus.irq), 0);
    check_eq("rst.batch_cnt", 32'(bus.batch_cnt), 0);
    rst = 1'b0;

    // 1: a done every 14 cycles.
    step(1, 0, 0);
    for (int p = 0; p < 4; p++) begin
      idle_n(13);
      step(1, 1, 0);
    end
    check_eq("t1.irq", 32'(bus.irq), 1);
    check_eq("t1.batch_cnt", 32'(bus.batch_cnt), 4);
    check_eq("t1.gap_max", 32'(bus.gap_max), 13);
    check_eq("t1.err", 32'(bus.err), 0);

    // 2a: ack coincident with done starts a new batch without overflow.
    idle_n(5);
    check_eq("t2.irq_held", 32'(bus.irq), 1);
    step(1, 1, 1);
    check_eq("t2.irq", 32'(bus.irq), 0);
    check_eq("t2.batch_cnt", 32'(bus.batch_cnt), 1);
    check_eq("t2.ovf", 32'(bus.ovf), 0);
    for (int p = 0; p < 3; p++) begin
      idle_n(4);
      step(1, 1, 0);
    end
    // 2b: done two cycles before ack is discarded and sets ovf.
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    check_eq("t2b.ovf", 32'(bus.ovf), 1);
    check_eq("t2b.batch_cnt", 32'(bus.batch_cnt), 0);
    for (int p = 0; p < 4; p++) begin
      idle_n(3);
      step(1, 1, 0);
    end
    check_eq("t2b.ovf_sticky", 32'(bus.ovf), 1);
    check_eq("t2b.irq", 32'(bus.irq), 1);
    step(1, 0, 1);

    // 3: stall after 31 idle COLLECT cycles.
    idle_n(30);
    check_eq("t3.err_before", 32'(bus.err), 0);
    step(1, 0, 0);
    check_eq("t3.err", 32'(bus.err), 1);
    idle_n(3);
    step(0, 0, 0);
    step(1, 0, 0);
    idle_n(30);
    step(1, 1, 0);
    check_eq("t3b.err", 32'(bus.err), 0);
    check_eq("t3b.gap_max", 32'(bus.gap_max), 30);

    // 4: done on the last idle cycle before timeout, including the batch-completing one.
    for (int p = 0; p < 3; p++) begin
      idle_n(30);
      step(1, 1, 0);
    end
    check_eq("t4.irq", 32'(bus.irq), 1);
    check_eq("t4.err", 32'(bus.err), 0);
    check_eq("t4.batch_cnt", 32'(bus.batch_cnt), 4);

    // 5: drop enable in REPORT (after forcing ovf) and in ERROR.
    step(1, 1, 0);
    check_eq("t5.ovf_set", 32'(bus.ovf), 1);
    step(0, 0, 0);
    check_eq("t5.irq", 32'(bus.irq), 0);
    check_eq("t5.batch_cnt", 32'(bus.batch_cnt), 0);
    step(1, 0, 0);
    check_eq("t5.gap_max", 32'(bus.gap_max), 0);
    check_eq("t5.ovf", 32'(bus.ovf), 0);
    idle_n(31);
    check_eq("t5.err_set", 32'(bus.err), 1);
    step(0, 0, 0);
    check_eq("t5.err", 32'(bus.err), 0);

    // 6: async reset mid-batch, between clock edges.
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    check_eq("t6.batch_cnt_pre", 32'(bus.batch_cnt), 2);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("t6.async_cnt", 32'(bus.batch_cnt), 0);
    check_eq("t6.async_gap_max", 32'(bus.gap_max), 0);
    compare_all("t6.async");
    #3;
    rst = 1'b0;
    step(1, 0, 0);
    step(1, 1, 0);
    check_eq("t6.restart_cnt", 32'(bus.batch_cnt), 1);

    // Random traffic in segments of varying done density and ack eagerness.
    for (int seg = 0; seg < 60; seg++) begin
      int unsigned dprob;
      int unsigned aprob;
      dprob = $urandom_range(0, 3) == 0 ? 1 : $urandom_range(5, 60);
      aprob = $urandom_range(5, 50);
      for (int c = 0; c < 60; c++) begin
        bit en;
        bit d;
        bit a;
        en = ($urandom_range(0, 199) != 0);
        d  = ($urandom_range(0, 99) < dprob);
        a  = ($urandom_range(0, 99) < aprob);
        step(en, d, a);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
